// File: rtl/daq_multi_capture_if.sv
// Wishbone classic bus bundle shared by the capture engine's master and slave ports.
// Master drives request/data and the slave returns read data and ack/err/rty.
interface daq_multi_capture_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_m;
    logic [DW-1:0] dat_s;
    logic [3:0]    sel;
    logic          we;
    logic          cyc;
    logic          stb;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack;
    logic          err;
    logic          rty;

    modport master (
        output adr, dat_m, sel, we, cyc, stb, cti, bte,
        input  dat_s, ack, err, rty
    );

    modport slave (
        input  adr, dat_m, sel, we, cyc, stb, cti, bte,
        output dat_s, ack, err, rty
    );
endinterface

// File: rtl/daq_multi_capture.sv
// Multi-channel sample capture into a circular buffer via Wishbone; strobe to stb >= 3 cycles.
// Full FIFO stalls the arbiter; held samples overwrite (counted) until granted.
module daq_multi_capture #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int CHANNELS = 4,
    parameter int SW       = 16,
    parameter int DEPTH    = 16
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst_n,
    input  logic [CHANNELS-1:0]    ch_valid,
    input  logic [CHANNELS*SW-1:0] ch_data,
    daq_multi_capture_if.master    wb_m,
    daq_multi_capture_if.slave     wb_s,
    output logic                   irq
);
    localparam int PW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FAW = $clog2(DEPTH);

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t r_state, w_next;

    logic                r_enable, r_irq_en;
    logic [CHANNELS-1:0] r_mask;
    logic [AW-1:0]       r_base;
    logic [15:0]         r_len, r_idx;
    logic [7:0]          r_ovf;
    logic                r_bus_err, r_wrapped;
    logic                r_s_ack;
    logic [DW-1:0]       r_s_dat;

    logic [CHANNELS-1:0] r_pend;
    logic [SW-1:0]       r_hold [CHANNELS];
    logic [PW-1:0]       r_ptr;

    logic [31:0]         r_mem [DEPTH];
    logic [FAW:0]        r_wp, r_rp;

    logic                w_s_req, w_s_wr;
    logic                w_wr_ctrl, w_wr_base, w_wr_len, w_wr_stat;
    logic [DW-1:0]       w_rd;
    logic [CHANNELS-1:0] w_acc, w_req;
    logic                w_gnt_vld;
    logic [PW-1:0]       w_gidx, w_c;
    logic [3:0]          w_ovf_inc;
    logic [8:0]          w_ovf_sum;
    logic [31:0]         w_word, w_head;
    logic                w_full, w_empty, w_push, w_pop;
    logic                w_adv, w_set_err, w_wrap, w_in_req;
    logic                w_unused;

    // ---------------- register slave ----------------
    assign w_s_req   = wb_s.cyc & wb_s.stb & ~r_s_ack;
    assign w_s_wr    = w_s_req & wb_s.we;
    assign w_wr_ctrl = w_s_wr & (wb_s.adr[3:2] == 2'd0);
    assign w_wr_base = w_s_wr & (wb_s.adr[3:2] == 2'd1);
    assign w_wr_len  = w_s_wr & (wb_s.adr[3:2] == 2'd2);
    assign w_wr_stat = w_s_wr & (wb_s.adr[3:2] == 2'd3);

    always_comb begin
        w_rd = '0;
        case (wb_s.adr[3:2])
            2'd0:    w_rd = DW'({r_mask, 6'b0, r_irq_en, r_enable});
            2'd1:    w_rd = DW'(r_base);
            2'd2:    w_rd = DW'(r_len);
            default: w_rd = DW'({r_wrapped, r_bus_err, 6'b0, r_ovf, r_idx});
        endcase
    end

    assign wb_s.ack   = r_s_ack;
    assign wb_s.dat_s = r_s_dat;
    assign wb_s.err   = 1'b0;
    assign wb_s.rty   = 1'b0;
    assign irq        = r_wrapped & r_irq_en;

    // ---------------- capture and arbitration ----------------
    assign w_acc = ch_valid & r_mask & {CHANNELS{r_enable && (r_len != 16'd0)}};
    assign w_req = r_pend & {CHANNELS{r_enable}};

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gidx    = '0;
        w_c       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_c = PW'((int'(r_ptr) + i) % CHANNELS);
            if (!w_full && !w_gnt_vld && w_req[w_c]) begin
                w_gnt_vld = 1'b1;
                w_gidx    = w_c;
            end
        end
    end

    // A grant in the same cycle as a new strobe is a reload, not a loss.
    always_comb begin
        w_ovf_inc = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_acc[c] && r_pend[c] && !(w_gnt_vld && (w_gidx == PW'(c))))
                w_ovf_inc = w_ovf_inc + 4'd1;
        end
    end

    assign w_ovf_sum = {1'b0, (w_wr_stat ? 8'h00 : r_ovf)} + {5'b0, w_ovf_inc};

    always_comb begin
        w_word            = '0;
        w_word[SW-1:0]    = r_hold[w_gidx];
        w_word[31:24]     = 8'(w_gidx);
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_pend <= '0;
            r_ptr  <= '0;
            for (int c = 0; c < CHANNELS; c++) r_hold[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!r_enable) begin
                    r_pend[c] <= 1'b0;
                end else if (w_acc[c]) begin
                    r_pend[c] <= 1'b1;
                    r_hold[c] <= ch_data[c*SW +: SW];
                end else if (w_gnt_vld && (w_gidx == PW'(c))) begin
                    r_pend[c] <= 1'b0;
                end
            end
            if (w_gnt_vld)
                r_ptr <= (w_gidx == PW'(CHANNELS - 1)) ? '0 : w_gidx + 1'b1;
        end
    end

    // ---------------- sample FIFO ----------------
    assign w_push  = w_gnt_vld;
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[FAW] != r_rp[FAW]) && (r_wp[FAW-1:0] == r_rp[FAW-1:0]);
    assign w_head  = r_mem[r_rp[FAW-1:0]];

    always_ff @(posedge wb_clk) begin
        if (w_push) r_mem[r_wp[FAW-1:0]] <= w_word;
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    // ---------------- bus master FSM ----------------
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) r_state <= ST_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_adv     = 1'b0;
        w_set_err = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_empty) w_next = ST_REQ;
            default: begin
                if (wb_m.ack) begin
                    w_pop  = 1'b1;
                    w_adv  = 1'b1;
                    w_next = ST_IDLE;
                end else if (wb_m.err) begin
                    w_pop     = 1'b1;
                    w_set_err = 1'b1;
                    w_next    = ST_IDLE;
                end else if (wb_m.rty) begin
                    w_next = ST_IDLE;
                end
            end
        endcase
    end

    assign w_in_req   = (r_state == ST_REQ);
    assign w_wrap     = ({1'b0, r_idx} + 17'd1) == {1'b0, r_len};
    assign wb_m.cyc   = w_in_req;
    assign wb_m.stb   = w_in_req;
    assign wb_m.we    = w_in_req;
    assign wb_m.sel   = w_in_req ? 4'hF : 4'h0;
    assign wb_m.cti   = 3'b000;
    assign wb_m.bte   = 2'b00;
    assign wb_m.adr   = w_in_req ? r_base + {{(AW-18){1'b0}}, r_idx, 2'b00} : '0;
    assign wb_m.dat_m = w_in_req ? DW'(w_head) : '0;

    // ---------------- configuration and status ----------------
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_s_ack   <= 1'b0;
            r_s_dat   <= '0;
            r_enable  <= 1'b0;
            r_irq_en  <= 1'b0;
            r_mask    <= '0;
            r_base    <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_ovf     <= '0;
            r_bus_err <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_s_ack <= w_s_req;
            if (w_s_req) r_s_dat <= w_rd;
            if (w_wr_ctrl) begin
                r_enable <= wb_s.dat_m[0];
                r_irq_en <= wb_s.dat_m[1];
                r_mask   <= wb_s.dat_m[8 +: CHANNELS];
            end
            if (w_wr_base) r_base <= {wb_s.dat_m[AW-1:2], 2'b00};
            if (w_wr_len)  r_len  <= wb_s.dat_m[15:0];
            // Software repositioning the buffer wins over a concurrent ack.
            if (w_wr_base || w_wr_len) r_idx <= '0;
            else if (w_adv)            r_idx <= w_wrap ? 16'd0 : r_idx + 16'd1;
            r_ovf <= w_ovf_sum[8] ? 8'hFF : w_ovf_sum[7:0];
            if (w_set_err)      r_bus_err <= 1'b1;
            else if (w_wr_stat) r_bus_err <= 1'b0;
            if (w_adv && w_wrap) r_wrapped <= 1'b1;
            else if (w_wr_stat)  r_wrapped <= 1'b0;
        end
    end

    assign w_unused = ^{wb_s.adr[AW-1:4], wb_s.adr[1:0], wb_s.sel, wb_s.cti, wb_s.bte,
                        wb_m.dat_s};
endmodule

// File: tb/tb_daq_multi_capture.sv
// Directed bench for daq_multi_capture: a scoreboard of expected bus writes is
// compared against a log kept by a simple memory responder on the master port.
module tb_daq_multi_capture;
    localparam int CH = 4;
    localparam int SW = 16;
    localparam int KACK = 0, KERR = 1, KRTY = 2;

    logic             wb_clk = 1'b0;
    logic             wb_rst_n = 1'b0;
    logic [CH-1:0]    ch_valid = '0;
    logic [CH*SW-1:0] ch_data = '0;
    logic             irq;

    daq_multi_capture_if #(.AW(32), .DW(32)) wbm ();
    daq_multi_capture_if #(.AW(32), .DW(32)) wbs ();

    daq_multi_capture #(.DW(32), .AW(32), .CHANNELS(CH), .SW(SW), .DEPTH(2)) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .wb_m     (wbm.master),
        .wb_s     (wbs.slave),
        .irq      (irq)
    );

    always #5 wb_clk = ~wb_clk;

    // Responder state: hold/plan written only by the stimulus, log only by the responder.
    logic        hold = 1'b0;
    int          plan = KACK;
    int          plan_id = 0;
    int          used_id = 0;
    int          kind;
    logic [31:0] log_adr [256];
    logic [31:0] log_dat [256];
    int          log_kind [256];
    int          log_n = 0;

    always @(negedge wb_clk) begin
        wbm.ack = 1'b0;
        wbm.err = 1'b0;
        wbm.rty = 1'b0;
        if (wb_rst_n && wbm.cyc && wbm.stb && !hold && log_n < 256) begin
            kind = KACK;
            if (plan_id != used_id) begin
                kind    = plan;
                used_id = plan_id;
            end
            if (kind == KERR)      wbm.err = 1'b1;
            else if (kind == KRTY) wbm.rty = 1'b1;
            else                   wbm.ack = 1'b1;
            log_adr[log_n]  = wbm.adr;
            log_dat[log_n]  = wbm.dat_m;
            log_kind[log_n] = kind;
            log_n++;
        end
    end

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        int          kind;
    } ev_t;

    ev_t exp_q[$];
    int  rd = 0;
    int  total = 0;
    int  bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input int k);
        ev_t e;
        e.adr  = a;
        e.dat  = d;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        int  n;
        ev_t e;
        n = exp_q.size();
        for (int i = 0; i < 300; i++) begin
            if (log_n - rd >= n) break;
            @(negedge wb_clk);
        end
        repeat (6) @(negedge wb_clk);
        chk({tag, "_count"}, 32'(log_n - rd), 32'(n));
        while (exp_q.size() > 0 && rd < log_n) begin
            e = exp_q.pop_front();
            chk({tag, "_adr"},  log_adr[rd], e.adr);
            chk({tag, "_dat"},  log_dat[rd], e.dat);
            chk({tag, "_kind"}, 32'(log_kind[rd]), 32'(e.kind));
            rd++;
        end
        exp_q.delete();
        rd = log_n;
    endtask

    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] q);
        @(negedge wb_clk);
        wbs.adr   = a;
        wbs.dat_m = d;
        wbs.we    = w;
        wbs.sel   = 4'hF;
        wbs.cyc   = 1'b1;
        wbs.stb   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk);
            if (wbs.ack) break;
        end
        chk("slave_ack", {31'b0, wbs.ack}, 32'd1);
        q       = wbs.dat_s;
        wbs.cyc = 1'b0;
        wbs.stb = 1'b0;
        wbs.we  = 1'b0;
    endtask

    task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_access(1'b1, a, d, q);
    endtask

    task automatic reg_rd_chk(input string tag, input logic [31:0] a, input logic [31:0] expv);
        logic [31:0] q;
        wb_access(1'b0, a, 32'h0, q);
        chk(tag, q, expv);
    endtask

    task automatic strobe(input logic [CH-1:0] m, input logic [CH*SW-1:0] d);
        @(negedge wb_clk);
        ch_valid = m;
        ch_data  = d;
        @(negedge wb_clk);
        ch_valid = '0;
    endtask

    task automatic do_reset();
        @(negedge wb_clk);
        wb_rst_n = 1'b0;
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
    endtask

    localparam logic [31:0] A_CTRL = 32'h0, A_BASE = 32'h4, A_LEN = 32'h8, A_STAT = 32'hC;

    initial begin
        int lat;
        int n0;
        wbm.dat_s = '0;
        wbs.adr = '0; wbs.dat_m = '0; wbs.sel = '0; wbs.we = 1'b0;
        wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.cti = '0; wbs.bte = '0;

        // Reset values
        repeat (3) @(negedge wb_clk);
        chk("rst_cyc", {31'b0, wbm.cyc}, 32'd0);
        chk("rst_stb", {31'b0, wbm.stb}, 32'd0);
        chk("rst_adr", wbm.adr, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_sack", {31'b0, wbs.ack}, 32'd0);
        wb_rst_n = 1'b1;
        reg_rd_chk("rst_status", A_STAT, 32'h0);
        reg_rd_chk("rst_ctrl", A_CTRL, 32'h0);

        // Single sample and capture latency
        reg_wr(A_BASE, 32'h1000);
        reg_wr(A_LEN, 32'd4);
        reg_wr(A_CTRL, 32'h101);
        expect_wr(32'h1000, 32'h0000_1234, KACK);
        @(negedge wb_clk);
        ch_valid = 4'b0001;
        ch_data  = 64'h1234;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge wb_clk);
            ch_valid = '0;
            if (wbm.stb) begin
                lat = i;
                break;
            end
        end
        chk("stb_latency", 32'(lat), 32'd3);
        drain("single");
        reg_rd_chk("single_status", A_STAT, 32'h0000_0001);

        // Wrap and interrupt
        reg_wr(A_LEN, 32'd2);
        reg_wr(A_CTRL, 32'h203);
        reg_rd_chk("wrap_ctrl", A_CTRL, 32'h203);
        expect_wr(32'h1000, 32'h0100_A001, KACK);
        expect_wr(32'h1004, 32'h0100_A002, KACK);
        expect_wr(32'h1000, 32'h0100_A003, KACK);
        for (int i = 1; i <= 3; i++) begin
            strobe(4'b0010, 64'(32'hA000 + i) << 16);
            repeat (4) @(negedge wb_clk);
        end
        drain("wrap");
        reg_rd_chk("wrap_status", A_STAT, 32'h8000_0001);
        chk("wrap_irq", {31'b0, irq}, 32'd1);
        reg_wr(A_STAT, 32'h0);
        chk("irq_cleared", {31'b0, irq}, 32'd0);
        reg_rd_chk("wrap_status_clr", A_STAT, 32'h0000_0001);

        // Arbitration from a fresh pointer
        do_reset();
        reg_wr(A_BASE, 32'h1000);
        reg_wr(A_LEN, 32'd16);
        reg_wr(A_CTRL, 32'hF01);
        for (int c = 0; c < 4; c++)
            expect_wr(32'h1000 + 32'(4 * c), (32'(c) << 24) | (32'h10 + 32'(c)), KACK);
        strobe(4'hF, {16'h13, 16'h12, 16'h11, 16'h10});
        drain("arb");
        reg_rd_chk("arb_status", A_STAT, 32'h0000_0004);

        // Overflow with acks held off
        hold = 1'b1;
        expect_wr(32'h1010, 32'h21, KACK);
        expect_wr(32'h1014, 32'h22, KACK);
        expect_wr(32'h1018, 32'h26, KACK);
        reg_wr(A_CTRL, 32'h101);
        for (int i = 1; i <= 6; i++) begin
            @(negedge wb_clk);
            ch_valid = 4'b0001;
            ch_data  = 64'(32'h20 + i);
        end
        @(negedge wb_clk);
        ch_valid = '0;
        repeat (4) @(negedge wb_clk);
        reg_rd_chk("ovf_status", A_STAT, 32'h0003_0004);
        hold = 1'b0;
        drain("ovf");

        // Retry then ack, then error then ack
        plan = KRTY;
        plan_id++;
        expect_wr(32'h101C, 32'h31, KRTY);
        expect_wr(32'h101C, 32'h31, KACK);
        strobe(4'b0001, 64'h31);
        drain("rty");
        plan = KERR;
        plan_id++;
        expect_wr(32'h1020, 32'h32, KERR);
        strobe(4'b0001, 64'h32);
        drain("err");
        expect_wr(32'h1020, 32'h33, KACK);
        strobe(4'b0001, 64'h33);
        drain("after_err");
        reg_rd_chk("err_status", A_STAT, 32'h4003_0009);

        // Reset in the middle of a transfer
        reg_wr(A_LEN, 32'd1);
        reg_wr(A_CTRL, 32'h103);
        expect_wr(32'h1000, 32'h51, KACK);
        strobe(4'b0001, 64'h51);
        drain("pre_rst");
        chk("pre_rst_irq", {31'b0, irq}, 32'd1);
        hold = 1'b1;
        strobe(4'b0001, 64'h52);
        for (int i = 0; i < 20; i++) begin
            if (wbm.stb) break;
            @(negedge wb_clk);
        end
        chk("stb_before_rst", {31'b0, wbm.stb}, 32'd1);
        @(negedge wb_clk);
        wb_rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", {31'b0, wbm.cyc}, 32'd0);
        chk("mid_rst_stb", {31'b0, wbm.stb}, 32'd0);
        chk("mid_rst_irq", {31'b0, irq}, 32'd0);
        n0 = log_n;
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        hold = 1'b0;
        repeat (20) @(negedge wb_clk);
        chk("no_write_after_rst", 32'(log_n), 32'(n0));
        reg_rd_chk("post_rst_status", A_STAT, 32'h0);
        reg_rd_chk("post_rst_ctrl", A_CTRL, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
